// File: rtl/seg_pkg.sv
// Shared glyph and digit-enable constants for the two-digit scan driver.
// All values are active-high; board polarity is applied once at the output register.
package seg_pkg;

    typedef enum logic {SelOnes, SelTens} sel_e;

    // Segment order is {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_0   = 7'b0111111;
    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_7   = 7'b0000111;
    localparam logic [6:0] SEG_8   = 7'b1111111;
    localparam logic [6:0] SEG_9   = 7'b1101111;
    localparam logic [6:0] SEG_ERR = 7'b1000000;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;
    localparam logic [1:0] AN_NONE = 2'b00;

endpackage

// File: rtl/bcd2seg_scan_if.sv
// Capture/display bundle between the BCD source, the scan driver and the display pins.
interface bcd2seg_scan_if;
    logic       load;
    logic [3:0] dec_h;
    logic [3:0] dec_l;
    logic       blank_lz;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (output load, dec_h, dec_l, blank_lz, input seg, an);
    modport slave  (input load, dec_h, dec_l, blank_lz, output seg, an);
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD code to active-high 7-segment glyph; codes 10-15 show a dash.
module bcd_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] glyph_o
);

    always_comb begin
        glyph_o = SEG_ERR;
        case (code_i)
            4'd0:    glyph_o = SEG_0;
            4'd1:    glyph_o = SEG_1;
            4'd2:    glyph_o = SEG_2;
            4'd3:    glyph_o = SEG_3;
            4'd4:    glyph_o = SEG_4;
            4'd5:    glyph_o = SEG_5;
            4'd6:    glyph_o = SEG_6;
            4'd7:    glyph_o = SEG_7;
            4'd8:    glyph_o = SEG_8;
            4'd9:    glyph_o = SEG_9;
            default: glyph_o = SEG_ERR;
        endcase
    end

endmodule

// File: rtl/bcd2seg_scan.sv
// Two-digit multiplexed 7-segment driver: latches BCD digits on load and scans them
// with a dark cycle at each digit switch, leading-zero blanking and registered outputs.
module bcd2seg_scan
    import seg_pkg::*;
#(
    parameter int unsigned DIV        = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    bcd2seg_scan_if.slave  bus
);

    localparam int unsigned CntW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [6:0]  SegMask = {7{ACTIVE_LOW}};
    localparam logic [1:0]  AnMask  = {2{ACTIVE_LOW}};

    logic [CntW-1:0] cnt_q, cnt_d;
    sel_e            sel_q, sel_d;
    logic [3:0]      lat_h_q, lat_h_d;
    logic [3:0]      lat_l_q, lat_l_d;
    logic [6:0]      seg_q, seg_d;
    logic [1:0]      an_q, an_d;

    logic       wrap;
    logic [3:0] digit;
    logic [6:0] glyph;
    logic [6:0] seg_act;
    logic [1:0] an_act;

    assign digit = (sel_q == SelTens) ? lat_h_q : lat_l_q;

    bcd_to_seg7 u_dec (
        .code_i  (digit),
        .glyph_o (glyph)
    );

    always_comb begin
        wrap    = (cnt_q == CntW'(DIV - 1));
        cnt_d   = wrap ? '0 : cnt_q + CntW'(1);
        sel_d   = sel_q;
        lat_h_d = bus.load ? bus.dec_h : lat_h_q;
        lat_l_d = bus.load ? bus.dec_l : lat_l_q;
        seg_act = SEG_OFF;
        an_act  = AN_NONE;

        if (wrap) begin
            // Dark cycle at the digit switch to avoid ghosting.
            sel_d = (sel_q == SelOnes) ? SelTens : SelOnes;
        end else if (sel_q == SelTens) begin
            an_act  = AN_TENS;
            seg_act = (bus.blank_lz && lat_h_q == 4'd0) ? SEG_OFF : glyph;
        end else begin
            an_act  = AN_ONES;
            seg_act = glyph;
        end

        seg_d = seg_act ^ SegMask;
        an_d  = an_act ^ AnMask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            sel_q   <= SelOnes;
            lat_h_q <= 4'd0;
            lat_l_q <= 4'd0;
            seg_q   <= SEG_OFF ^ SegMask;
            an_q    <= AN_NONE ^ AnMask;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            lat_h_q <= lat_h_d;
            lat_l_q <= lat_l_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_bcd2seg_scan.sv
// Randomized bench for bcd2seg_scan: two instances (active-high and active-low) share
// stimulus and are compared every cycle against a frame-position reference model.
module tb_bcd2seg_scan;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [3:0] dec_h;
    logic [3:0] dec_l;
    logic       blank_lz;

    always #5 clk = ~clk;

    bcd2seg_scan_if if_hi ();
    bcd2seg_scan_if if_lo ();

    assign if_hi.load     = load;
    assign if_hi.dec_h    = dec_h;
    assign if_hi.dec_l    = dec_l;
    assign if_hi.blank_lz = blank_lz;
    assign if_lo.load     = load;
    assign if_lo.dec_h    = dec_h;
    assign if_lo.dec_l    = dec_l;
    assign if_lo.blank_lz = blank_lz;

    bcd2seg_scan #(.DIV(DIV), .ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk (clk),
        .rst (rst),
        .bus (if_hi)
    );

    bcd2seg_scan #(.DIV(DIV), .ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk (clk),
        .rst (rst),
        .bus (if_lo)
    );

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference model: edges since reset, latched digits, expected active-high outputs.
    int unsigned k;
    logic [3:0]  m_h, m_l;
    logic [6:0]  exp_seg;
    logic [1:0]  exp_an;
    logic [6:0]  glyph_tab [16];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        int unsigned pos;
        int unsigned slot;
        if (rst) begin
            k       = 0;
            m_h     = 4'd0;
            m_l     = 4'd0;
            exp_seg = 7'b0000000;
            exp_an  = 2'b00;
        end else begin
            pos  = k % DIV;
            slot = (k / DIV) % 2;
            if (pos == DIV - 1) begin
                exp_seg = 7'b0000000;
                exp_an  = 2'b00;
            end else if (slot == 1) begin
                exp_an  = 2'b10;
                exp_seg = (blank_lz && m_h == 4'd0) ? 7'b0000000 : glyph_tab[m_h];
            end else begin
                exp_an  = 2'b01;
                exp_seg = glyph_tab[m_l];
            end
            if (load) begin
                m_h = dec_h;
                m_l = dec_l;
            end
            k++;
        end
    endtask

    task automatic tick(input string tag);
        logic [6:0] inv_seg;
        logic [1:0] inv_an;
        @(posedge clk);
        model_edge();
        #1;
        inv_seg = ~exp_seg;
        inv_an  = ~exp_an;
        check({tag, ".seg"},    {1'b0, if_hi.seg}, {1'b0, exp_seg});
        check({tag, ".an"},     {6'b0, if_hi.an},  {6'b0, exp_an});
        check({tag, ".seg_al"}, {1'b0, if_lo.seg}, {1'b0, inv_seg});
        check({tag, ".an_al"},  {6'b0, if_lo.an},  {6'b0, inv_an});
    endtask

    task automatic load_digits(input logic [3:0] h, input logic [3:0] l, input string tag);
        load  = 1'b1;
        dec_h = h;
        dec_l = l;
        tick(tag);
        load  = 1'b0;
    endtask

    initial begin
        glyph_tab = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                      7'b1111111, 7'b1101111, 7'b1000000, 7'b1000000,
                      7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
        k = 0; m_h = 0; m_l = 0;

        // Reset held with load active must not latch.
        rst = 1'b1; load = 1'b1; dec_h = 4'd9; dec_l = 4'd9; blank_lz = 1'b0;
        repeat (3) tick("reset");
        rst = 1'b0; load = 1'b0;
        tick("first");

        load_digits(4'd4, 4'd7, "scan_ld");
        repeat (16) tick("scan");

        blank_lz = 1'b1;
        load_digits(4'd0, 4'd5, "lz_ld");
        repeat (8) tick("lz_on");
        blank_lz = 1'b0;
        repeat (8) tick("lz_off");

        load_digits(4'hC, 4'd3, "err_ld");
        repeat (8) tick("err");

        // Align the next edge with a wrap edge, then load there.
        for (int i = 0; i < DIV && (k % DIV) != DIV - 1; i++) tick("align");
        load_digits(4'd9, 4'd9, "wrap_ld");
        repeat (8) tick("wrap");

        repeat (2) tick("mid");
        rst = 1'b1;
        tick("mid_rst");
        rst = 1'b0;
        repeat (6) tick("restart");

        for (int i = 0; i < 2000; i++) begin
            rst      = ($urandom_range(0, 99) == 0);
            load     = ($urandom_range(0, 3) == 0);
            dec_h    = 4'($urandom_range(0, 15));
            dec_l    = 4'($urandom_range(0, 15));
            blank_lz = 1'($urandom_range(0, 1));
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd2seg_scan.md
# bcd2seg_scan

Two-digit, time-multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD converter. It captures the converter's tens/ones BCD digits on a `load` strobe and holds them. It scans the two digits onto a shared segment bus with per-digit enables, a dark cycle at each digit switch, optional leading-zero blanking and an error glyph for non-decimal codes. All outputs are registered.

## Interface
- `DIV`, 50000: refresh prescaler terminal count; each digit slot lasts `DIV` clocks; legal range ≥ 2.
- `ACTIVE_LOW`, 1: 1 = `seg` and `an` are active-low (common-anode board); 0 = active-high.

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset; sampled on the `clk` rising edge.
- `load`  in  1  capture strobe; samples `dec_h`/`dec_l` on the same edge.
- `dec_h`  in  4  tens BCD digit from the converter.
- `dec_l`  in  4  ones BCD digit from the converter.
- `blank_lz`  in  1  1 = blank the tens digit when the latched tens value is 0.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, registered.
- `an`  out  2  digit enables; bit 0 = ones, bit 1 = tens; registered.

## Operation
- Latch: on an edge with `load`=1, `lat_h`/`lat_l` ← `dec_h`/`dec_l`; otherwise hold. `load` has no handshake and can be asserted every cycle. The upstream pipeline asserts it 3 clocks after presenting `h`.
- Prescaler `cnt`, width clog2(DIV): increments each clock; at `DIV-1` it wraps to 0 and toggles `sel`. `sel`=0 selects ones, `sel`=1 selects tens.
- Output register, per edge:
  - If `cnt`==DIV-1 (wrap edge): `an` ← all off and `seg` ← all off. This dark cycle suppresses ghosting.
  - Else: `an` ← enable bit for `sel` only, and `seg` ← encode(digit[sel]).
- Encoding, active-high form, {g..a}: 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
- Codes 10–15: error glyph "-", g only (1000000).
- With `ACTIVE_LOW`=1, `seg` and `an` are bitwise inverted.
- Leading-zero blanking: when `sel`=1, `blank_lz`=1 and `lat_h`==0, `seg` ← all off. `an[1]` is still asserted.
- `blank_lz` is sampled live, not latched.

## Timing
- Reset state: `cnt`=0, `sel`=0, `lat_h`=`lat_l`=0, `seg`=all off, `an`=all off (polarity-adjusted). `rst` overrides `load` and wrap on the same edge.
- First edge after reset release: `an` selects ones and `seg` shows "0".
- Load latency: `load` at edge N → `seg` shows the new value of the selected digit at edge N+1, unless N+1 is a dark edge.
- Frame: each digit is lit for DIV-1 cycles, then dark for 1 cycle. Full refresh period is 2·DIV clocks.
- Load coincident with a wrap edge: both take effect. The new digit appears after the dark cycle.
- Reset mid-frame: the next cycle is the reset state; the scan restarts on ones.
- `an` is never one-hot to both digits simultaneously, in any cycle.

## Structure
- Shared package `seg_pkg`:
  - segment glyph constants SEG_0..SEG_9 and SEG_ERR, SEG_OFF;
  - digit enable constants AN_ONES, AN_TENS, AN_NONE;
  - these are in active-high form, and polarity is applied once at the output.
- One sub-module: `bcd_to_seg7`, a combinational 4-bit code → 7-bit glyph decoder, instantiated once on the muxed digit.
- Prescaler, select, latch and output register stay in the top module.

## Test plan
All scenarios use DIV=4 and ACTIVE_LOW=0.
- Reset: hold `rst` 3 cycles with `load`=1 and `dec`=9/9 → `seg`=0000000 and `an`=00 throughout. After release, the first edge gives `an`=01 and `seg`=0111111.
- Scan: load 4/7 → `an` sequence 01,01,01,00,10,10,10,00 repeating. `seg` shows 0000111 on the ones slots and 1100110 on the tens slots.
- Leading zero: load 0/5 with `blank_lz`=1 → tens slots give `an`=10, `seg`=0000000. With `blank_lz`=0 → tens slots give `seg`=0111111.
- Invalid code: load 12/3 (tens=4'hC) → tens slots give `seg`=1000000, ones slots give 1001111.
- Coincident events: `load` 9/9 on the wrap edge → the next cycle is dark, then tens shows 1101111. `rst` asserted mid-slot → the next cycle has all outputs off.
- Polarity: rerun the scan scenario with ACTIVE_LOW=1 → `seg`/`an` are the exact bitwise inverse of the ACTIVE_LOW=0 trace.
